ws_inst_sequencer: RTL



---
 rtl/ws_inst_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ws_inst_sequencer.sv
// ws_inst_sequencer
//   Generates the complete 34-bit instruction stream for one 3x3 convolution
//   tile on the 8x8 weight-stationary core. For each kernel position it loads
//   the kernel into L0 and the PEs, streams activations, executes, and drains
//   the OFIFO into psum SRAM. It then runs an accumulation pass over psum SRAM,
//   strobing the SFP acc bit for each output pixel.
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   start        : one-cycle start pulse, honoured only while idle
//   ofifo_valid  : OFIFO has a row ready to be read
//   inst         : registered core instruction word
//   busy         : tile in progress
//   done         : one-cycle pulse when the tile is complete
//   out_valid    : sfp_out holds output pixel out_idx this cycle
//   out_idx      : output pixel index 0..15
module ws_inst_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic        out_valid,
    output logic [3:0]  out_idx
);

    localparam int unsigned ROW      = 8;
    localparam int unsigned COL      = 8;
    localparam int unsigned LEN_KIJ  = 9;
    localparam int unsigned IN_W     = 6;
    localparam int unsigned LEN_NIJ  = IN_W * IN_W;
    localparam int unsigned LEN_ONIJ = 16;
    localparam int unsigned AW       = 11;
    localparam int unsigned CW       = 6;

    localparam logic [AW-1:0] W_BASE    = 11'd0;
    localparam logic [AW-1:0] A_BASE    = 11'd1024;
    localparam logic [33:0]   IDLE_WORD = 34'h1_800C_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_KL0, S_KPE, S_KWAIT, S_AL0, S_EXEC, S_EWAIT, S_DRAIN, S_ACC, S_DONE
    } state_t;

    state_t        state, nxt_state;
    logic [3:0]    k, nxt_k;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [3:0]    o, nxt_o;
    logic          drain_wr, nxt_wr;
    logic          nxt_ov;

    // psum address of kernel position kk's contribution to output pixel oo
    function automatic logic [AW-1:0] acc_addr(logic [3:0] oo, logic [3:0] kk);
        logic [3:0] kr;
        logic [3:0] kc;
        kr = (kk >= 4'd6) ? 4'd2 : ((kk >= 4'd3) ? 4'd1 : 4'd0);
        kc = kk - 4'd3 * kr;
        return AW'(kk) * AW'(LEN_NIJ)
             + (AW'(oo[3:2]) + AW'(kr)) * AW'(IN_W)
             + AW'(oo[1:0]) + AW'(kc);
    endfunction

    // Instruction word for the cycle described by (s, kk, c, oo, wr)
    function automatic logic [33:0] mk_inst(state_t s, logic [3:0] kk, logic [CW-1:0] c,
                                            logic [3:0] oo, logic wr);
        logic          acc_b, cen_p, wen_p, cen_x, wen_x, rd_o, l0_rd, l0_wr, exe, ld;
        logic [AW-1:0] a_p, a_x;
        acc_b = 1'b0; cen_p = 1'b1; wen_p = 1'b1; a_p = '0;
        cen_x = 1'b1; wen_x = 1'b1; a_x = '0;
        rd_o  = 1'b0; l0_rd = 1'b0; l0_wr = 1'b0; exe = 1'b0; ld = 1'b0;
        case (s)
            S_KL0: begin
                if (c < CW'(COL)) begin
                    cen_x = 1'b0;
                    a_x   = W_BASE + AW'(kk) * AW'(COL) + AW'(c);
                end
                // L0 write trails the SRAM read by its one-cycle latency
                l0_wr = (c != '0);
            end
            S_KPE: begin
                l0_rd = 1'b1;
                ld    = 1'b1;
            end
            S_AL0: begin
                if (c < CW'(LEN_NIJ)) begin
                    cen_x = 1'b0;
                    a_x   = A_BASE + AW'(c);
                end
                l0_wr = (c != '0);
            end
            S_EXEC: begin
                l0_rd = 1'b1;
                exe   = 1'b1;
            end
            S_DRAIN: begin
                if (wr) begin
                    rd_o  = 1'b1;
                    cen_p = 1'b0;
                    wen_p = 1'b0;
                    a_p   = AW'(kk) * AW'(LEN_NIJ) + AW'(c);
                end
            end
            S_ACC: begin
                if (c < CW'(LEN_KIJ)) begin
                    cen_p = 1'b0;
                    a_p   = acc_addr(oo, 4'(c));
                end
                acc_b = (c != '0) && (c <= CW'(LEN_KIJ));
            end
            default: ;
        endcase
        return {acc_b, cen_p, wen_p, a_p, cen_x, wen_x, a_x, rd_o, 2'b00, l0_rd, l0_wr, exe, ld};
    endfunction

    // Next-state and counter update
    always_comb begin
        nxt_state = state;
        nxt_k     = k;
        nxt_cnt   = cnt;
        nxt_o     = o;
        nxt_wr    = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                nxt_state = S_KL0;
                nxt_k     = '0;
                nxt_cnt   = '0;
                nxt_o     = '0;
            end
            S_KL0: if (cnt == CW'(COL)) begin
                nxt_state = S_KPE;
                nxt_cnt   = '0;
            end else nxt_cnt = cnt + CW'(1);
            S_KPE: if (cnt == CW'(COL - 1)) begin
                nxt_state = S_KWAIT;
                nxt_cnt   = '0;
            end else nxt_cnt = cnt + CW'(1);
            S_KWAIT: if (cnt == CW'(ROW - 1)) begin
                nxt_state = S_AL0;
                nxt_cnt   = '0;
            end else nxt_cnt = cnt + CW'(1);
            S_AL0: if (cnt == CW'(LEN_NIJ)) begin
                nxt_state = S_EXEC;
                nxt_cnt   = '0;
            end else nxt_cnt = cnt + CW'(1);
            S_EXEC: if (cnt == CW'(LEN_NIJ - 1)) begin
                nxt_state = S_EWAIT;
                nxt_cnt   = '0;
            end else nxt_cnt = cnt + CW'(1);
            S_EWAIT: if (ofifo_valid) begin
                nxt_state = S_DRAIN;
                nxt_cnt   = '0;
                nxt_wr    = 1'b1;
            end
            // cnt is the psum row written this cycle (if drain_wr) or the next one pending
            S_DRAIN: begin
                if (drain_wr && cnt == CW'(LEN_NIJ - 1)) begin
                    nxt_cnt = '0;
                    if (k == 4'(LEN_KIJ - 1)) begin
                        nxt_state = S_ACC;
                        nxt_o     = '0;
                    end else begin
                        nxt_state = S_KL0;
                        nxt_k     = k + 4'd1;
                    end
                end else begin
                    nxt_cnt = cnt + CW'(drain_wr);
                    nxt_wr  = ofifo_valid;
                end
            end
            // 9 reads, acc trailing by one, then a gap cycle presenting the pixel
            S_ACC: if (cnt == CW'(LEN_KIJ + 1)) begin
                nxt_cnt = '0;
                if (o == 4'(LEN_ONIJ - 1)) nxt_state = S_DONE;
                else                       nxt_o     = o + 4'd1;
            end else nxt_cnt = cnt + CW'(1);
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    assign nxt_ov = (nxt_state == S_ACC) && (nxt_cnt == CW'(LEN_KIJ + 1));

    // State and registered outputs; outputs reflect the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            cnt       <= '0;
            o         <= '0;
            drain_wr  <= 1'b0;
            inst      <= IDLE_WORD;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            state     <= nxt_state;
            k         <= nxt_k;
            cnt       <= nxt_cnt;
            o         <= nxt_o;
            drain_wr  <= nxt_wr;
            inst      <= mk_inst(nxt_state, nxt_k, nxt_cnt, nxt_o, nxt_wr);
            busy      <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done      <= (nxt_state == S_DONE);
            out_valid <= nxt_ov;
            out_idx   <= nxt_ov ? nxt_o : 4'd0;
        end
    end

endmodule
